// File: rtl/cache_bus_pkg.sv
// Shared types for the cache-side memory bus: arbiter state, grant encodings and
// a bundled request struct used to mux the two cache masters onto one port.
package cache_bus_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_GNT_I = 2'd1,
        ARB_GNT_D = 2'd2
    } arb_state_t;

    // One-hot grant encodings {D,I}
    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_I    = 2'b01;
    localparam logic [1:0] GNT_D    = 2'b10;

    typedef struct packed {
        logic        req;
        logic        wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        wlast;
    } cache_req_t;

    localparam cache_req_t CACHE_REQ_IDLE = '0;

endpackage

// File: rtl/burst_beat_counter.sv
// Beat counter for one memory burst: synchronous clear has priority over
// increment, and tc_o flags that the current beat is the last of a full burst.
module burst_beat_counter #(
    parameter int unsigned CNT_W = 4,
    parameter int unsigned TERM  = 7
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    input  logic inc_i,
    output logic tc_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear wins over increment
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Terminal count: the beat that returns now completes the burst
    always_comb begin
        tc_o = (cnt_q == CNT_W'(TERM));
    end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Shares the external memory port between the I-cache and the D-cache. One master
// owns the port for a whole burst; handshakes are routed back to the owner only.
module cache_mem_arbiter
    import cache_bus_pkg::*;
#(
    parameter int unsigned BURST_LEN = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_addr_ok,
    output logic        i_data_ok,
    input  logic        d_req,
    input  logic        d_wen,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic        d_wlast,
    output logic        d_addr_ok,
    output logic        d_data_ok,
    output logic [31:0] rdata,
    output logic        mem_req,
    output logic        mem_wen,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_wlast,
    input  logic [31:0] mem_rdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    output logic [1:0]  grant
);

    localparam int unsigned CNT_W = $clog2(BURST_LEN) + 1;

    arb_state_t state_q;
    logic       last_d_q;      // previous burst owner was the D-cache
    logic       wlast_seen_q;  // final write address beat has been accepted

    logic       granted_i;
    logic       granted_d;
    logic       granted;
    cache_req_t i_bus;
    cache_req_t d_bus;
    cache_req_t sel_bus;
    logic       beat_done;
    logic       wlast_fire;
    logic       tc;
    logic       burst_end;

    assign granted_i = (state_q == ARB_GNT_I);
    assign granted_d = (state_q == ARB_GNT_D);
    assign granted   = granted_i | granted_d;

    // The I-cache only refills, so its write fields are tied off
    assign i_bus = '{req: i_req, wen: 1'b0, addr: i_addr, wdata: 32'h0, wlast: 1'b0};
    assign d_bus = '{req: d_req, wen: d_wen, addr: d_addr, wdata: d_wdata, wlast: d_wlast};

    // Downstream request mux: the owner drives the port, idle drives zeros
    always_comb begin
        sel_bus = CACHE_REQ_IDLE;
        case (state_q)
            ARB_GNT_I: sel_bus = i_bus;
            ARB_GNT_D: sel_bus = d_bus;
            default:   sel_bus = CACHE_REQ_IDLE;
        endcase
    end

    assign mem_req   = sel_bus.req;
    assign mem_wen   = sel_bus.wen;
    assign mem_addr  = sel_bus.addr;
    assign mem_wdata = sel_bus.wdata;
    assign mem_wlast = sel_bus.wlast;

    assign i_addr_ok = granted_i & mem_addr_ok;
    assign i_data_ok = granted_i & mem_data_ok;
    assign d_addr_ok = granted_d & mem_addr_ok;
    assign d_data_ok = granted_d & mem_data_ok;
    assign rdata     = granted ? mem_rdata : 32'h0;
    assign grant     = {granted_d, granted_i};

    // Stray data_ok while idle never counts
    assign beat_done  = granted & mem_data_ok;
    assign wlast_fire = granted_d & sel_bus.req & sel_bus.wen & sel_bus.wlast & mem_addr_ok;

    // Reads end on the last counted beat; writes end on the first data_ok at or after
    // the wlast address beat, with the full-count limit as a backstop.
    always_comb begin
        burst_end = 1'b0;
        if (beat_done) begin
            if (granted_d && d_wen) begin
                burst_end = wlast_seen_q | wlast_fire | tc;
            end else begin
                burst_end = tc;
            end
        end
    end

    burst_beat_counter #(
        .CNT_W (CNT_W),
        .TERM  (BURST_LEN - 1)
    ) u_beat_cnt (
        .clk   (clk),
        .reset (reset),
        .clr_i (burst_end | ~granted),
        .inc_i (beat_done),
        .tc_o  (tc)
    );

    // Arbiter FSM: alternating-priority grant in idle, hold until burst end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ARB_IDLE;
            last_d_q     <= 1'b0;
            wlast_seen_q <= 1'b0;
        end else begin
            case (state_q)
                ARB_IDLE: begin
                    wlast_seen_q <= 1'b0;
                    if (d_req && (!i_req || !last_d_q)) begin
                        state_q <= ARB_GNT_D;
                    end else if (i_req) begin
                        state_q <= ARB_GNT_I;
                    end
                end
                ARB_GNT_I, ARB_GNT_D: begin
                    if (burst_end) begin
                        state_q      <= ARB_IDLE;
                        last_d_q     <= granted_d;
                        wlast_seen_q <= 1'b0;
                    end else if (wlast_fire) begin
                        wlast_seen_q <= 1'b1;
                    end
                end
                default: begin
                    state_q      <= ARB_IDLE;
                    wlast_seen_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter: reset, single refills, contention with
// alternating priority, a non-pipelined write burst, and reset mid-burst.
module tb_cache_mem_arbiter;
    import cache_bus_pkg::*;

    localparam int unsigned BURST_LEN = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_addr_ok;
    logic        i_data_ok;
    logic        d_req;
    logic        d_wen;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_wlast;
    logic        d_addr_ok;
    logic        d_data_ok;
    logic [31:0] rdata;
    logic        mem_req;
    logic        mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_wlast;
    logic [31:0] mem_rdata;
    logic        mem_addr_ok;
    logic        mem_data_ok;
    logic [1:0]  grant;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cache_mem_arbiter #(
        .BURST_LEN (BURST_LEN)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .i_req       (i_req),
        .i_addr      (i_addr),
        .i_addr_ok   (i_addr_ok),
        .i_data_ok   (i_data_ok),
        .d_req       (d_req),
        .d_wen       (d_wen),
        .d_addr      (d_addr),
        .d_wdata     (d_wdata),
        .d_wlast     (d_wlast),
        .d_addr_ok   (d_addr_ok),
        .d_data_ok   (d_data_ok),
        .rdata       (rdata),
        .mem_req     (mem_req),
        .mem_wen     (mem_wen),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_wlast   (mem_wlast),
        .mem_rdata   (mem_rdata),
        .mem_addr_ok (mem_addr_ok),
        .mem_data_ok (mem_data_ok),
        .grant       (grant)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Handshake outputs packed as {i_addr_ok, i_data_ok, d_addr_ok, d_data_ok}
    function automatic logic [31:0] oks();
        return 32'({i_addr_ok, i_data_ok, d_addr_ok, d_data_ok});
    endfunction

    // One-cycle-per-beat read burst; returns in the first cycle after the burst
    task automatic read_burst(input logic is_d, input logic [31:0] base);
        for (int k = 0; k < int'(BURST_LEN); k++) begin
            if (is_d) d_addr = base + 32'(4 * k);
            else      i_addr = base + 32'(4 * k);
            mem_addr_ok = 1'b1;
            mem_data_ok = 1'b1;
            mem_rdata   = base ^ 32'(k);
            #1;
            chk("burst_grant", 32'(grant), is_d ? 32'(GNT_D) : 32'(GNT_I));
            chk("burst_oks", oks(), is_d ? 32'h3 : 32'hC);
            chk("burst_addr", mem_addr, base + 32'(4 * k));
            chk("burst_rdata", rdata, base ^ 32'(k));
            cyc();
        end
        mem_addr_ok = 1'b0;
        mem_data_ok = 1'b0;
    endtask

    initial begin
        reset       = 1'b0;
        i_req       = 1'b1;
        i_addr      = 32'h1234;
        d_req       = 1'b1;
        d_wen       = 1'b1;
        d_addr      = 32'h5678;
        d_wdata     = 32'hFFFF;
        d_wlast     = 1'b1;
        mem_rdata   = 32'hDEAD_BEEF;
        mem_addr_ok = 1'b0;
        mem_data_ok = 1'b0;

        // 1. Reset held: everything quiet despite requests and toggling handshakes
        for (int c = 0; c < 5; c++) begin
            cyc();
            mem_addr_ok = 1'($urandom_range(0, 1));
            mem_data_ok = 1'($urandom_range(0, 1));
            mem_rdata   = $urandom;
            #1;
            chk("rst_ctrl", 32'({grant, mem_req, mem_wen, mem_wlast}), 32'h0);
            chk("rst_oks", oks(), 32'h0);
            chk("rst_bus", mem_addr | mem_wdata | rdata, 32'h0);
        end
        i_req       = 1'b0;
        d_req       = 1'b0;
        d_wen       = 1'b0;
        d_wlast     = 1'b0;
        mem_addr_ok = 1'b0;
        mem_data_ok = 1'b0;
        cyc();
        reset = 1'b1;
        cyc();

        // 2. I refill alone: grant appears the cycle after the request
        i_req  = 1'b1;
        i_addr = 32'h1000;
        #1;
        chk("i_req_same_cycle", 32'({grant, mem_req}), 32'h0);
        cyc();
        chk("i_grant", 32'(grant), 32'(GNT_I));
        chk("i_memreq_wen", 32'({mem_req, mem_wen, mem_wlast}), 32'h4);
        read_burst(1'b0, 32'h1000);
        i_req = 1'b0;
        mem_data_ok = 1'b1;
        #1;
        chk("i_end_grant", 32'(grant), 32'(GNT_NONE));
        chk("idle_stray_oks", oks(), 32'h0);
        cyc();
        mem_data_ok = 1'b0;
        #1;
        chk("idle_stray_nostate", 32'(grant), 32'(GNT_NONE));

        // 3. Simultaneous requests, last winner I -> D first, bubble, then I
        i_req = 1'b1;
        d_req = 1'b1;
        d_wen = 1'b0;
        cyc();
        chk("both_d_first", 32'(grant), 32'(GNT_D));
        read_burst(1'b1, 32'h2000);
        d_req = 1'b0;
        #1;
        chk("bubble_grant", 32'({grant, mem_req}), 32'h0);
        cyc();
        chk("then_i", 32'(grant), 32'(GNT_I));
        read_burst(1'b0, 32'h3000);
        i_req = 1'b0;
        #1;
        chk("after_i_idle", 32'(grant), 32'(GNT_NONE));

        // 4. D write, one beat at a time, data_ok two cycles after addr_ok
        d_req = 1'b1;
        d_wen = 1'b1;
        cyc();
        chk("wr_grant", 32'(grant), 32'(GNT_D));
        for (int k = 0; k < int'(BURST_LEN); k++) begin
            d_addr      = 32'h4000 + 32'(4 * k);
            d_wdata     = 32'hD0 + 32'(k);
            d_wlast     = (k == int'(BURST_LEN) - 1);
            mem_addr_ok = 1'b1;
            #1;
            chk("wr_wdata", mem_wdata, 32'hD0 + 32'(k));
            chk("wr_ctrl", 32'({mem_req, mem_wen, mem_wlast}),
                (k == int'(BURST_LEN) - 1) ? 32'h7 : 32'h6);
            chk("wr_addr_ok", oks(), 32'h2);
            cyc();
            mem_addr_ok = 1'b0;
            cyc();
            mem_data_ok = 1'b1;
            #1;
            chk("wr_data_ok", oks(), 32'h1);
            chk("wr_held", 32'(grant), 32'(GNT_D));
            cyc();
            mem_data_ok = 1'b0;
        end
        d_req   = 1'b0;
        d_wen   = 1'b0;
        d_wlast = 1'b0;
        #1;
        chk("wr_end_idle", 32'(grant), 32'(GNT_NONE));

        // 5. D again (last winner D), I pending -> I wins next, then D
        d_req = 1'b1;
        cyc();
        chk("d_again", 32'(grant), 32'(GNT_D));
        i_req = 1'b1;
        read_burst(1'b1, 32'h5000);
        #1;
        chk("alt_bubble", 32'(grant), 32'(GNT_NONE));
        cyc();
        chk("alt_i_wins", 32'(grant), 32'(GNT_I));
        read_burst(1'b0, 32'h6000);
        i_req = 1'b0;
        cyc();
        chk("alt_d_next", 32'(grant), 32'(GNT_D));
        read_burst(1'b1, 32'h7000);
        d_req = 1'b0;
        cyc();

        // 6. Reset pulsed during beat 3 of an I refill
        i_req  = 1'b1;
        i_addr = 32'h8000;
        cyc();
        chk("r6_grant", 32'(grant), 32'(GNT_I));
        mem_data_ok = 1'b1;
        mem_addr_ok = 1'b1;
        cyc();
        cyc();
        cyc();
        reset = 1'b0;
        #1;
        chk("r6_async_grant", 32'({grant, mem_req}), 32'h0);
        chk("r6_async_oks", oks(), 32'h0);
        cyc();
        reset = 1'b1;
        i_req = 1'b0;
        #1;
        chk("r6_stray_oks", oks(), 32'h0);
        cyc();
        chk("r6_still_idle", 32'(grant), 32'(GNT_NONE));
        mem_data_ok = 1'b0;
        mem_addr_ok = 1'b0;
        // Last winner back to I after reset, so D wins a tie
        i_req = 1'b1;
        d_req = 1'b1;
        cyc();
        chk("r6_tie_d", 32'(grant), 32'(GNT_D));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
